// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the IF-stage fetch sequencer.
//   state_t    : sequencer states BOOT / RUN / HALTED
//   fq_entry_t : one fetch-queue entry {inst, pc4}
//   INST_W     : instruction width
//   DEFAULT_RESET_PC : default PC loaded on reset
package fetch_pkg;

   localparam int          INST_W           = 32;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [31:0]       pc4;
   } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of fetched {inst, pc4} entries.
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   push         : write push_entry at the tail
//   push_entry   : entry to enqueue
//   pop          : decode is accepting the head (ignored when empty)
//   flush        : discard all entries at the edge
//   out_valid    : head entry is valid (count != 0)
//   head         : head entry, forced to zero when the queue is empty
//   count        : current occupancy (0..FQ_DEPTH)
// Pop and push in the same cycle are allowed even when full.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int FQ_DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  fq_entry_t                 push_entry,
   input  logic                      pop,
   input  logic                      flush,
   output logic                      out_valid,
   output fq_entry_t                 head,
   output logic [$clog2(FQ_DEPTH):0] count
);

   localparam int PW = $clog2(FQ_DEPTH);
   localparam int CW = PW + 1;

   fq_entry_t         mem [FQ_DEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic              pop_eff;

   assign pop_eff   = pop & out_valid;
   assign out_valid = (count != '0);
   // Zero head when empty so out_inst/out_pc4 read 0 after reset and flush.
   assign head      = out_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop_eff) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop_eff})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible through count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage fetch sequencer. Owns the PC, drives the IROM word
// address, buffers fetched words in fetch_queue and presents {inst, pc4}
// to decode over a valid/ready handshake.
// Handshake: the head transfers on a rising edge where out_valid and
// out_ready are both high; out_valid never depends on out_ready.
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   redirect_valid/_pc  : one-cycle PC change from EX (flushes the queue)
//   halt                : level, stop fetching while high
//   irom_addr/irom_data : IROM word address (pc[IROM_AW+1:2]) / read data
//   out_valid/ready     : decode handshake
//   out_inst/out_pc4    : head instruction / its fetch address + 4
//   pc                  : current fetch PC
//   fsm_state           : current sequencer state (state_t encoding)
// Optional build macro FETCH_PERF_EN adds perf_fetch, perf_stall and
// perf_flush saturating counters.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          FQ_DEPTH = 2,
   parameter int          IROM_AW  = 14
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   input  logic               halt,
   output logic [IROM_AW-1:0] irom_addr,
   input  logic [31:0]        irom_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_inst,
   output logic [31:0]        out_pc4,
   output logic [31:0]        pc,
   output logic [1:0]         fsm_state
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        perf_fetch,
   output logic [31:0]        perf_stall,
   output logic [31:0]        perf_flush
`endif
);

   localparam int CW = $clog2(FQ_DEPTH) + 1;

   state_t          state_q;
   state_t          state_d;
   logic [31:0]     pc_q;
   logic [31:0]     pc_d;
   logic            fetch_en;
   logic            pop_now;
   logic            full;
   logic            q_valid;
   logic [CW-1:0]   q_count;
   fq_entry_t       head;
   fq_entry_t       push_entry;

   assign pop_now = q_valid & out_ready;
   assign full    = (q_count == CW'(FQ_DEPTH));

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      // A pop this cycle frees a slot, so a full queue can still accept.
      fetch_en = (state_q == RUN) & ~halt & ~redirect_valid & (~full | pop_now);

      case (state_q)
         BOOT:        state_d = RUN;
         RUN, HALTED: state_d = halt ? HALTED : RUN;
         default:     state_d = BOOT;
      endcase

      if (redirect_valid) begin
         pc_d = redirect_pc & 32'hFFFF_FFFC;
      end else if (fetch_en) begin
         pc_d = pc_q + 32'd4;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   assign push_entry.inst = irom_data;
   assign push_entry.pc4  = pc_q + 32'd4;

   fetch_queue #(
      .FQ_DEPTH (FQ_DEPTH)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .push       (fetch_en),
      .push_entry (push_entry),
      .pop        (out_ready),
      .flush      (redirect_valid),
      .out_valid  (q_valid),
      .head       (head),
      .count      (q_count)
   );

   assign irom_addr = pc_q[IROM_AW+1:2];
   assign out_valid = q_valid;
   assign out_inst  = head.inst;
   assign out_pc4   = head.pc4;
   assign pc        = pc_q;
   assign fsm_state = state_q;

`ifdef FETCH_PERF_EN
   logic stall_now;
   logic flush_hit;

   assign stall_now = (state_q == RUN) & ~halt & ~redirect_valid & ~fetch_en;
   // An entry popped in the redirect cycle was consumed, not discarded.
   assign flush_hit = redirect_valid & (q_count > CW'(pop_now));

   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_fetch <= '0;
         perf_stall <= '0;
         perf_flush <= '0;
      end else begin
         if (fetch_en && perf_fetch != 32'hFFFF_FFFF) begin
            perf_fetch <= perf_fetch + 32'd1;
         end
         if (stall_now && perf_stall != 32'hFFFF_FFFF) begin
            perf_stall <= perf_stall + 32'd1;
         end
         if (flush_hit && perf_flush != 32'hFFFF_FFFF) begin
            perf_flush <= perf_flush + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized and directed stimulus for fetch_ctrl, checked
// by a scoreboard fed from a transaction-level reference model.
module tb_fetch_ctrl;
   import fetch_pkg::*;

   localparam int          DEPTH  = 2;
   localparam int          AW     = 14;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic          clk;
   logic          rst;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic          halt;
   logic [AW-1:0] irom_addr;
   logic [31:0]   irom_data;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_inst;
   logic [31:0]   out_pc4;
   logic [31:0]   pc;
   logic [1:0]    fsm_state;
`ifdef FETCH_PERF_EN
   logic [31:0]   perf_fetch;
   logic [31:0]   perf_stall;
   logic [31:0]   perf_flush;
   logic [31:0]   m_fetch;
   logic [31:0]   m_stall;
   logic [31:0]   m_flush;
`endif

   fetch_ctrl #(
      .RESET_PC (RST_PC),
      .FQ_DEPTH (DEPTH),
      .IROM_AW  (AW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .irom_addr      (irom_addr),
      .irom_data      (irom_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc4        (out_pc4),
      .pc             (pc),
      .fsm_state      (fsm_state)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch     (perf_fetch),
      .perf_stall     (perf_stall),
      .perf_flush     (perf_flush)
`endif
   );

   // ---------------- clock / reset / IROM ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // IROM word i holds 32'h1000_0000 + i.
   assign irom_data = 32'h1000_0000 + 32'(irom_addr);

   function automatic logic [31:0] rom_at(input logic [31:0] a);
      return 32'h1000_0000 + {18'b0, a[15:2]};
   endfunction

   // ---------------- scoreboard state ----------------
   int            total = 0;
   int            bad   = 0;
   logic [63:0]   exp_q[$];
   logic [31:0]   mpc;
   state_t        mstate;
   bit            started = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // ---------------- reference model (at each rising edge) ----------------
   // Queue occupancy is the scoreboard size: the monitor has already removed
   // the word decode takes this cycle, so a free slot exists iff size < DEPTH.
   initial begin
      bit fetch;
      forever begin
         @(posedge clk);
         if (!rst) begin
            mpc    = RST_PC;
            mstate = BOOT;
            exp_q.delete();
`ifdef FETCH_PERF_EN
            m_fetch = 0; m_stall = 0; m_flush = 0;
`endif
         end else begin
            fetch = (mstate == RUN) && !halt && !redirect_valid && (exp_q.size() < DEPTH);
`ifdef FETCH_PERF_EN
            if (fetch) m_fetch = sat_inc(m_fetch);
            if (mstate == RUN && !halt && !redirect_valid && !fetch) m_stall = sat_inc(m_stall);
            if (redirect_valid && exp_q.size() > 0) m_flush = sat_inc(m_flush);
`endif
            if (redirect_valid) begin
               exp_q.delete();
               mpc = redirect_pc & 32'hFFFF_FFFC;
            end else if (fetch) begin
               exp_q.push_back({rom_at(mpc), mpc + 32'd4});
               mpc = mpc + 32'd4;
            end
            if (mstate == BOOT) mstate = RUN;
            else                mstate = halt ? HALTED : RUN;
         end
         started = 1;
      end
   end

   // ---------------- monitor (falling edge) ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            check("pc", 64'(pc), 64'(mpc));
            check("irom_addr", 64'(irom_addr), 64'(mpc[15:2]));
            check("state", 64'(fsm_state), 64'(mstate));
            check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (mstate == BOOT) begin
               check("boot_inst", 64'(out_inst), 64'd0);
               check("boot_pc4", 64'(out_pc4), 64'd0);
            end
            if (exp_q.size() != 0) begin
               check("head_inst", 64'(out_inst), 64'(exp_q[0][63:32]));
               check("head_pc4", 64'(out_pc4), 64'(exp_q[0][31:0]));
               if (out_ready) void'(exp_q.pop_front());
            end
`ifdef FETCH_PERF_EN
            check("perf_fetch", 64'(perf_fetch), 64'(m_fetch));
            check("perf_stall", 64'(perf_stall), 64'(m_stall));
            check("perf_flush", 64'(perf_flush), 64'(m_flush));
`endif
         end
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic r, input logic rdy, input logic h,
                        input logic rv, input logic [31:0] rp, input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
         rst            = r;
         out_ready      = rdy;
         halt           = h;
         redirect_valid = rv;
         redirect_pc    = rp;
      end
   endtask

   initial begin
      rst = 1'b0; out_ready = 1'b1; halt = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0;

      drive(0, 1, 0, 0, 32'h0, 3);            // reset
      drive(1, 1, 0, 0, 32'h0, 10);           // free-running stream
      drive(1, 0, 0, 0, 32'h0, 6);            // back-pressure, queue fills
      drive(1, 1, 0, 0, 32'h0, 6);            // release
      drive(1, 0, 0, 0, 32'h0, 3);            // fill again
      drive(1, 0, 0, 1, 32'h0000_0103, 1);    // redirect while full
      drive(1, 1, 0, 0, 32'h0, 6);
      drive(1, 1, 1, 0, 32'h0, 5);            // halt, queue drains
      drive(1, 1, 0, 0, 32'h0, 6);            // resume at frozen pc
      drive(1, 1, 0, 1, 32'hFFFF_FFF4, 1);    // PC wrap region
      drive(1, 1, 0, 0, 32'h0, 8);
      drive(1, 0, 0, 0, 32'h0, 4);            // full queue
      drive(0, 0, 0, 0, 32'h0, 1);            // reset mid-stream
      drive(1, 1, 0, 1, 32'h0000_0040, 1);    // redirect during BOOT
      drive(1, 1, 0, 0, 32'h0, 4);
      drive(1, 1, 1, 1, 32'h0000_0082, 1);    // halt + redirect together
      drive(1, 1, 1, 0, 32'h0, 2);
      drive(1, 1, 0, 0, 32'h0, 4);

      repeat (800) begin
         drive($urandom_range(0, 199) != 0,
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 7) == 0,
               $urandom_range(0, 15) == 0,
               $urandom(), 1);
      end

      drive(1, 1, 0, 0, 32'h0, 6);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
